// File: rtl/alu_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: opcodes, FSM states
// and opcode classification helpers.
package alu_serial_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ops that go through the adder path (and so produce overflow).
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Ops that subtract: B is inverted and the carry chain seeded with 1.
  function automatic logic is_sub(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_serial_seq_bit_eval.sv
// One-bit ALU slice: full adder plus nand/nor/xor based logic functions,
// selected by op. Purely combinational; the sequencer owns all state.
module alu_bit_eval
  import alu_serial_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       res,
  output logic       cout
);

  logic bx, axb, nand_ab, nor_ab, sum;

  // Adder bit on (a, b^inv, cin) and per-op result select.
  always_comb begin
    bx      = b ^ is_sub(op);
    axb     = a ^ bx;
    nand_ab = ~(a & b);
    nor_ab  = ~(a | b);
    sum     = axb ^ cin;
    cout    = (a & bx) | (axb & cin);
    res     = sum;
    case (op)
      OP_XOR:  res = a ^ b;
      OP_AND:  res = ~nand_ab;
      OP_NAND: res = nand_ab;
      OP_NOR:  res = nor_ab;
      OP_OR:   res = ~nor_ab;
      default: res = sum;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: evaluates one bit per cycle, LSB first, carrying
// between bits in a flop. Optional abort input enabled by ALUSEQ_ABORT_EN.
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
`ifdef ALUSEQ_ABORT_EN
  ,
  input  logic             abort
`endif
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  // Holds the WIDTH-1 bits collected so far; the final bit goes straight
  // into the committed result, so no LSB slot is needed here.
  logic [WIDTH-2:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic             bit_res, bit_cout, last_bit, ovf_bit, abort_req;

  alu_bit_eval u_bit (
    .a    (a_q[cnt]),
    .b    (b_q[cnt]),
    .cin  (carry),
    .op   (op_q),
    .res  (bit_res),
    .cout (bit_cout)
  );

`ifdef ALUSEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign zero = (result == '0);

  // Next shift-register image, last-bit detect and MSB overflow term.
  always_comb begin
    sreg_nxt = {bit_res, sreg};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
    ovf_bit  = carry ^ bit_cout;
  end

  // Sequencer FSM with registered handshake, result and flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cnt   <= '0;
            carry <= is_sub(op);
            sreg  <= '0;
            state <= ST_RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else if (state == ST_DONE) begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            sreg  <= sreg_nxt[WIDTH-1:1];
            carry <= bit_cout;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
              state <= ST_DONE;
              ready <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              case (op_q)
                OP_SLT: begin
                  result   <= {{(WIDTH-1){1'b0}}, bit_res ^ ovf_bit};
                  carryout <= 1'b0;
                  overflow <= ovf_bit;
                end
                OP_ADD, OP_SUB: begin
                  result   <= sreg_nxt;
                  carryout <= bit_cout;
                  overflow <= ovf_bit;
                end
                default: begin
                  result   <= sreg_nxt;
                  carryout <= 1'b0;
                  overflow <= 1'b0;
                end
              endcase
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq (WIDTH=32).
module tb_alu_serial_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n, start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             ready, busy, done, carryout, overflow, zero;
  logic [WIDTH-1:0] result;
`ifdef ALUSEQ_ABORT_EN
  logic             abort;
`endif

  int nerr = 0;
  int nchk = 0;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carryout (carryout),
    .overflow (overflow),
    .zero     (zero)
`ifdef ALUSEQ_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one op at a negedge, then wait (bounded) for done; n = negedges
  // from the start cycle to the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int n);
    op = o; a = x; b = y; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (!done && n < 100);
  endtask

  task automatic chk_res(input string tag, input logic [31:0] r, input logic co,
                         input logic ov, input logic z);
    chk({tag, ".result"},   result,   r);
    chk({tag, ".carryout"}, carryout, co);
    chk({tag, ".overflow"}, overflow, ov);
    chk({tag, ".zero"},     zero,     z);
  endtask

  initial begin
    int n;
    int pulses;
    reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
`ifdef ALUSEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst.ready", ready, 1'b1);
    chk("rst.busy",  busy,  1'b0);
    chk("rst.done",  done,  1'b0);
    chk_res("rst", 32'h0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);

    // ADD with carry out of MSB and zero result; latency WIDTH+1
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, n);
    chk("add.latency", n, 33);
    chk("add.done", done, 1'b1);
    chk_res("add", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("add.done_pulse", done, 1'b0);
    chk("add.idle_ready", ready, 1'b1);

    // SUB with signed overflow
    run_op(3'd1, 32'h8000_0000, 32'h0000_0001, n);
    chk("sub.latency", n, 33);
    chk_res("sub", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // SLT cases
    run_op(3'd3, 32'hFFFF_FFFB, 32'h0000_0003, n);
    chk_res("slt1", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op(3'd3, 32'h7FFF_FFFF, 32'h8000_0000, n);
    chk_res("slt2", 32'h0000_0000, 1'b0, 1'b1, 1'b1);

    // Logic ops
    run_op(3'd2, 32'hF0F0_A5A5, 32'h0FF0_FF00, n);
    chk_res("xor", 32'hFF00_5AA5, 1'b0, 1'b0, 1'b0);
    run_op(3'd4, 32'hF0F0_A5A5, 32'h0FF0_FF00, n);
    chk_res("and", 32'h00F0_A500, 1'b0, 1'b0, 1'b0);
    run_op(3'd5, 32'hF0F0_A5A5, 32'h0FF0_FF00, n);
    chk_res("nand", 32'hFF0F_5AFF, 1'b0, 1'b0, 1'b0);
    run_op(3'd6, 32'hF0F0_A5A5, 32'h0FF0_FF00, n);
    chk_res("nor", 32'h000F_005A, 1'b0, 1'b0, 1'b0);
    run_op(3'd7, 32'hF0F0_A5A5, 32'h0FF0_FF00, n);
    chk_res("or", 32'hFFF0_FFA5, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held through RUN, operands changed mid-run
    op = 3'd0; a = 32'd5; b = 32'd3; start = 1'b1;
    @(negedge clk);
    chk("b2b.busy1", busy, 1'b1);
    op = 3'd1; a = 32'd100; b = 32'd1;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.latency1", n, 33);
    chk("b2b.result1", result, 32'd8);
    @(negedge clk);
    start = 1'b0;
    chk("b2b.no_gap_busy", busy, 1'b1);
    chk("b2b.done_low", done, 1'b0);
    chk("b2b.hold1", result, 32'd8);
    repeat (10) @(negedge clk);
    chk("b2b.hold_mid", result, 32'd8);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.done2", done, 1'b1);
    chk_res("b2b2", 32'h0000_0063, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

`ifdef ALUSEQ_ABORT_EN
    // Abort at bit 10: back to IDLE, previous result/flags retained
    op = 3'd7; a = 32'h1234_5678; b = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.ready", ready, 1'b1);
    chk("abort.busy", busy, 1'b0);
    chk("abort.done", done, 1'b0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort.no_done", pulses, 0);
    chk_res("abort", 32'h0000_0063, 1'b1, 1'b0, 1'b0);
`endif

    // Reset at bit 10 of a RUN: aborts with no done
    op = 3'd0; a = 32'd1; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mrst.ready", ready, 1'b1);
    chk("mrst.busy", busy, 1'b0);
    chk("mrst.done", done, 1'b0);
    chk_res("mrst", 32'h0, 1'b0, 1'b0, 1'b1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("mrst.no_done", pulses, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
